ddr_rd_checker: RTL and testbench

DDR_RD_CHECKER -- requirements
Module: ddr_rd_checker

---
 rtl/ddr_test_pkg.sv | 27 ++
 rtl/ddr_pattern_gen.sv | 28 ++
 rtl/ddr_rd_checker.sv | 171 +++++++++++++++++
 tb/tb_ddr_rd_checker.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_test_pkg.sv
// Shared definitions for the DDR traffic tester and read-data checker:
// bus widths, controller command codes, the default data pattern and the checker FSM encoding.
package ddr_test_pkg;

  localparam int DATA_W   = 128;
  localparam int ADDR_W   = 27;
  localparam int DATA_NUM = 64;

  localparam logic [2:0] WR_CMD = 3'b000;
  localparam logic [2:0] RD_CMD = 3'b001;

  localparam logic [DATA_W-1:0] INIT_DATA = 128'h0123_4567_890A_BCDE_FEDC_BA98_7654_3218;

  // Beat index reported for data that arrives while no burst is armed.
  localparam logic [5:0] ORPHAN_BEAT = 6'h3F;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_REPORT = 2'd2
  } chk_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ddr_pattern_gen.sv
// Incrementing data pattern source: load a seed, then step by one per consumed beat.
// The value wraps modulo 2^W; shared between the write-side tester and the read checker.
module ddr_pattern_gen #(
  parameter int W = ddr_test_pkg::DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] seed_i,
  input  logic         inc_i,
  output logic [W-1:0] value_o
);

  logic [W-1:0] value_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
    end else if (load_i) begin
      value_q <= seed_i;
    end else if (inc_i) begin
      value_q <= value_q + W'(1);
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/ddr_rd_checker.sv
// Checks read bursts returned by the DDR controller against an incrementing pattern,
// keeping pass/error statistics and a capture of the first failing beat since the last clear.
module ddr_rd_checker #(
  parameter int DATA_W  = ddr_test_pkg::DATA_W,
  parameter int ADDR_W  = ddr_test_pkg::ADDR_W,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              chk_start,
  input  logic [ADDR_W-1:0] chk_addr,
  input  logic [DATA_W-1:0] chk_seed,
  input  logic [5:0]        chk_beats,
  input  logic              clr_err,
  input  logic              app_rdata_valid,
  input  logic              app_rdata_end,
  input  logic [DATA_W-1:0] app_rdata,
  output logic              chk_busy,
  output logic              chk_done,
  output logic              chk_pass,
  output logic              err_sticky,
  output logic [15:0]       err_cnt,
  output logic              timeout_flag,
  output logic [31:0]       ok_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [5:0]        first_err_beat,
  output logic [DATA_W-1:0] first_err_exp,
  output logic [DATA_W-1:0] first_err_got
);
  import ddr_test_pkg::*;

  localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  chk_state_e        state_q;
  logic [5:0]        beat_idx_q, beats_q;
  logic [ADDR_W-1:0] addr_q;
  logic [TO_W-1:0]   to_q;
  logic              burst_err_q, done_q, pass_q;
  logic              err_sticky_q, err_sticky_d, tflag_q, tflag_d, cap_q, cap_d;
  logic [15:0]       err_cnt_q, err_cnt_d;
  logic [31:0]       ok_cnt_q, ok_cnt_d;
  logic [ADDR_W-1:0] fe_addr_q, fe_addr_d;
  logic [5:0]        fe_beat_q, fe_beat_d;
  logic [DATA_W-1:0] fe_exp_q, fe_exp_d, fe_got_q, fe_got_d;

  logic              start_acc, beat_v, beat_bad, beat_last, to_hit, orphan, err_evt, pass_now;
  logic [DATA_W-1:0] exp_data;

  ddr_pattern_gen #(.W(DATA_W)) u_pattern (
    .clk     (clk),
    .rst     (rst),
    .load_i  (start_acc),
    .seed_i  (chk_seed),
    .inc_i   (beat_v),
    .value_o (exp_data)
  );

  always_comb begin
    start_acc = (state_q == ST_IDLE) && chk_start;
    beat_v    = (state_q == ST_ARMED) && app_rdata_valid;
    beat_bad  = beat_v && ((app_rdata != exp_data) || !app_rdata_end);
    beat_last = beat_v && (beat_idx_q == beats_q);
    pass_now  = beat_last && !burst_err_q && !beat_bad;
    to_hit    = (state_q == ST_ARMED) && !app_rdata_valid && (to_q == TO_W'(TIMEOUT - 1));
    orphan    = (state_q != ST_ARMED) && app_rdata_valid;
    err_evt   = beat_bad || to_hit || orphan;

    // A clear in the same cycle as an error wipes the old state first, then records the new error.
    err_cnt_d    = clr_err ? 16'd0 : err_cnt_q;
    err_sticky_d = (clr_err ? 1'b0 : err_sticky_q) | err_evt;
    tflag_d      = (clr_err ? 1'b0 : tflag_q) | to_hit;
    ok_cnt_d     = clr_err ? 32'd0 : ok_cnt_q;
    cap_d        = clr_err ? 1'b0 : cap_q;
    fe_addr_d    = clr_err ? '0 : fe_addr_q;
    fe_beat_d    = clr_err ? '0 : fe_beat_q;
    fe_exp_d     = clr_err ? '0 : fe_exp_q;
    fe_got_d     = clr_err ? '0 : fe_got_q;

    if (err_evt) begin
      err_cnt_d = sat_inc16(err_cnt_d);
    end
    if (pass_now) begin
      ok_cnt_d = ok_cnt_d + 32'd1;
    end
    if (err_evt && !cap_d) begin
      cap_d     = 1'b1;
      fe_addr_d = addr_q;
      fe_beat_d = orphan ? ORPHAN_BEAT : beat_idx_q;
      fe_exp_d  = orphan ? '0 : exp_data;
      fe_got_d  = to_hit ? '0 : app_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      beat_idx_q   <= '0;
      beats_q      <= '0;
      addr_q       <= '0;
      to_q         <= '0;
      burst_err_q  <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_sticky_q <= 1'b0;
      err_cnt_q    <= '0;
      tflag_q      <= 1'b0;
      ok_cnt_q     <= '0;
      cap_q        <= 1'b0;
      fe_addr_q    <= '0;
      fe_beat_q    <= '0;
      fe_exp_q     <= '0;
      fe_got_q     <= '0;
    end else begin
      done_q <= 1'b0;
      pass_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (chk_start) begin
            state_q     <= ST_ARMED;
            addr_q      <= chk_addr;
            beats_q     <= chk_beats;
            beat_idx_q  <= '0;
            to_q        <= '0;
            burst_err_q <= 1'b0;
          end
        end
        ST_ARMED: begin
          if (beat_v) begin
            to_q <= '0;
            if (beat_last) begin
              state_q <= ST_REPORT;
              done_q  <= 1'b1;
              pass_q  <= pass_now;
            end else begin
              beat_idx_q  <= beat_idx_q + 6'd1;
              burst_err_q <= burst_err_q | beat_bad;
            end
          end else if (to_hit) begin
            state_q <= ST_REPORT;
            done_q  <= 1'b1;
          end else begin
            to_q <= to_q + TO_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      err_sticky_q <= err_sticky_d;
      err_cnt_q    <= err_cnt_d;
      tflag_q      <= tflag_d;
      ok_cnt_q     <= ok_cnt_d;
      cap_q        <= cap_d;
      fe_addr_q    <= fe_addr_d;
      fe_beat_q    <= fe_beat_d;
      fe_exp_q     <= fe_exp_d;
      fe_got_q     <= fe_got_d;
    end
  end

  assign chk_busy       = (state_q != ST_IDLE);
  assign chk_done       = done_q;
  assign chk_pass       = pass_q;
  assign err_sticky     = err_sticky_q;
  assign err_cnt        = err_cnt_q;
  assign timeout_flag   = tflag_q;
  assign ok_cnt         = ok_cnt_q;
  assign first_err_addr = fe_addr_q;
  assign first_err_beat = fe_beat_q;
  assign first_err_exp  = fe_exp_q;
  assign first_err_got  = fe_got_q;

endmodule

// File: tb/tb_ddr_rd_checker.sv
// Scoreboard bench for ddr_rd_checker: expected burst results are queued as beats are driven
// and matched (value and cycle) against chk_done pulses.
module tb_ddr_rd_checker;

  localparam int DW = 128;
  localparam int AW = 27;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          chk_start = 1'b0;
  logic [AW-1:0] chk_addr = '0;
  logic [DW-1:0] chk_seed = '0;
  logic [5:0]    chk_beats = '0;
  logic          clr_err = 1'b0;
  logic          app_rdata_valid = 1'b0;
  logic          app_rdata_end = 1'b0;
  logic [DW-1:0] app_rdata = '0;
  logic          chk_busy, chk_done, chk_pass, err_sticky, timeout_flag;
  logic [15:0]   err_cnt;
  logic [31:0]   ok_cnt;
  logic [AW-1:0] first_err_addr;
  logic [5:0]    first_err_beat;
  logic [DW-1:0] first_err_exp, first_err_got;

  ddr_rd_checker #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .chk_start(chk_start), .chk_addr(chk_addr), .chk_seed(chk_seed),
    .chk_beats(chk_beats), .clr_err(clr_err), .app_rdata_valid(app_rdata_valid),
    .app_rdata_end(app_rdata_end), .app_rdata(app_rdata), .chk_busy(chk_busy),
    .chk_done(chk_done), .chk_pass(chk_pass), .err_sticky(err_sticky), .err_cnt(err_cnt),
    .timeout_flag(timeout_flag), .ok_cnt(ok_cnt), .first_err_addr(first_err_addr),
    .first_err_beat(first_err_beat), .first_err_exp(first_err_exp), .first_err_got(first_err_got)
  );

  always #5 clk = ~clk;

  typedef struct { logic pass; int cyc; } exp_t;
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_drive_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every chk_done must match the oldest queued expectation.
  always @(posedge clk) begin
    #1;
    if (chk_done === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: chk_done=1 at cycle %0d, required no pending burst", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (chk_pass !== e.pass || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL burst_result: pass=%0b cycle=%0d, required pass=%0b cycle=%0d",
                   chk_pass, cyc, e.pass, e.cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input logic [AW-1:0] a, input logic [DW-1:0] s, input logic [5:0] nb);
    chk_start = 1'b1; chk_addr = a; chk_seed = s; chk_beats = nb;
    step();
    chk_start = 1'b0;
  endtask

  // Send n beats of seed+i; beat bad_idx gets bit 0 flipped. Queues the result on beat `last`.
  task automatic send_beats(input logic [DW-1:0] s, input int n, input int last,
                            input int bad_idx, input logic exp_pass);
    for (int i = 0; i < n; i++) begin
      logic [DW-1:0] d;
      d = s + DW'(i);
      if (i == bad_idx) d[0] = ~d[0];
      app_rdata_valid = 1'b1; app_rdata_end = 1'b1; app_rdata = d;
      if (i == last) sb.push_back('{exp_pass, cyc + 1});
      last_drive_cyc = cyc;
      step();
    end
    app_rdata_valid = 1'b0; app_rdata_end = 1'b0; app_rdata = '0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      step();
      n++;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL done_timeout: %0d bursts still pending, required 0", sb.size());
      sb.delete();
    end
    step();
    step();
  endtask

  task automatic test_reset();
    repeat (3) step();
    n_checks++;
    if ({chk_busy, chk_done, chk_pass, err_sticky, timeout_flag} !== 5'b0 ||
        err_cnt !== 16'd0 || ok_cnt !== 32'd0 || first_err_beat !== 6'd0 || first_err_got !== '0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%0b done=%0b err_cnt=%0h ok_cnt=%0h, required all zero",
               chk_busy, chk_done, err_cnt, ok_cnt);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_pass();
    logic [DW-1:0] s;
    s = 128'h0123_4567_890A_BCDE_FEDC_BA98_7654_3218;
    start_burst(27'h10, s, 6'd3);
    n_checks++;
    if (chk_busy !== 1'b1) begin
      n_fail++; $display("FAIL busy_armed: chk_busy=%0b, required 1", chk_busy);
    end
    send_beats(s, 4, 3, -1, 1'b1);
    wait_done();
    n_checks++;
    if (ok_cnt !== 32'd1 || err_cnt !== 16'd0 || err_sticky !== 1'b0 || chk_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL pass_stats: ok=%0d err=%0d sticky=%0b busy=%0b, required 1 0 0 0",
               ok_cnt, err_cnt, err_sticky, chk_busy);
    end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] s;
    s = '1;
    start_burst(27'h20, s, 6'd1);
    start_burst(27'h30, 128'h55, 6'd9);   // ignored while armed
    send_beats(s, 2, 1, -1, 1'b1);
    wait_done();
    n_checks++;
    if (ok_cnt !== 32'd2 || err_cnt !== 16'd0) begin
      n_fail++; $display("FAIL wrap_stats: ok=%0d err=%0d, required 2 0", ok_cnt, err_cnt);
    end
  endtask

  task automatic test_mismatch();
    logic [DW-1:0] s, e;
    s = 128'hA5A5_0000_1111_2222_3333_4444_5555_6660;
    e = s + DW'(2);
    start_burst(27'h5, s, 6'd3);
    send_beats(s, 4, 3, 2, 1'b0);
    wait_done();
    n_checks++;
    if (err_cnt !== 16'd1 || err_sticky !== 1'b1 || first_err_addr !== 27'h5 || first_err_beat !== 6'd2 ||
        first_err_exp !== e || first_err_got !== (e ^ 128'd1) || ok_cnt !== 32'd2) begin
      n_fail++;
      $display("FAIL first_capture: err=%0d addr=%0h beat=%0d exp=%0h got=%0h, required 1 5 2 %0h %0h",
               err_cnt, first_err_addr, first_err_beat, first_err_exp, first_err_got, e, e ^ 128'd1);
    end
    start_burst(27'h9, s, 6'd1);
    send_beats(s, 2, 1, 0, 1'b0);
    wait_done();
    n_checks++;
    if (err_cnt !== 16'd2 || first_err_addr !== 27'h5 || first_err_beat !== 6'd2 || first_err_exp !== e) begin
      n_fail++;
      $display("FAIL capture_hold: err=%0d addr=%0h beat=%0d, required 2 5 2",
               err_cnt, first_err_addr, first_err_beat);
    end
  endtask

  task automatic test_clr_collide();
    logic [DW-1:0] s;
    s = 128'h77;
    start_burst(27'h7, s, 6'd0);
    clr_err = 1'b1;
    app_rdata_valid = 1'b1; app_rdata_end = 1'b0; app_rdata = s;   // missing end marker
    sb.push_back('{1'b0, cyc + 1});
    step();
    clr_err = 1'b0; app_rdata_valid = 1'b0;
    wait_done();
    n_checks++;
    if (err_cnt !== 16'd1 || first_err_addr !== 27'h7 || first_err_beat !== 6'd0 ||
        first_err_got !== s || ok_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL clr_collide: err=%0d addr=%0h beat=%0d ok=%0d, required 1 7 0 0",
               err_cnt, first_err_addr, first_err_beat, ok_cnt);
    end
  endtask

  task automatic test_timeout();
    logic [DW-1:0] s;
    s = 128'h1000;
    clr_err = 1'b1; step(); clr_err = 1'b0;
    start_burst(27'h3, s, 6'd3);
    send_beats(s, 2, 3, -1, 1'b0);
    sb.push_back('{1'b0, last_drive_cyc + 16});
    wait_done();
    n_checks++;
    if (timeout_flag !== 1'b1 || err_cnt !== 16'd1 || first_err_beat !== 6'd2 ||
        first_err_got !== '0 || first_err_exp !== s + DW'(2)) begin
      n_fail++;
      $display("FAIL timeout_capture: tflag=%0b err=%0d beat=%0d got=%0h, required 1 1 2 0",
               timeout_flag, err_cnt, first_err_beat, first_err_got);
    end
  endtask

  task automatic test_orphan();
    clr_err = 1'b1; step(); clr_err = 1'b0;
    app_rdata_valid = 1'b1; app_rdata_end = 1'b1; app_rdata = 128'hBEEF;
    step();
    app_rdata_valid = 1'b0;
    n_checks++;
    if (err_cnt !== 16'd1 || first_err_beat !== 6'h3F || first_err_got !== 128'hBEEF || chk_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL orphan_one: err=%0d beat=%0h busy=%0b, required 1 3f 0", err_cnt, first_err_beat, chk_busy);
    end
    app_rdata_valid = 1'b1;
    repeat (70000) step();
    app_rdata_valid = 1'b0;
    n_checks++;
    if (err_cnt !== 16'hFFFF) begin
      n_fail++; $display("FAIL err_saturate: err=%0h, required ffff", err_cnt);
    end
    clr_err = 1'b1; step(); clr_err = 1'b0;
    n_checks++;
    if (err_cnt !== 16'd0 || err_sticky !== 1'b0 || timeout_flag !== 1'b0 || ok_cnt !== 32'd0 ||
        first_err_beat !== 6'd0 || first_err_got !== '0 || first_err_addr !== '0) begin
      n_fail++;
      $display("FAIL clear_stats: err=%0h sticky=%0b beat=%0h, required 0 0 0", err_cnt, err_sticky, first_err_beat);
    end
  endtask

  task automatic test_start_orphan();
    logic [DW-1:0] s;
    s = 128'hC0DE_0000;
    app_rdata_valid = 1'b1; app_rdata_end = 1'b1; app_rdata = 128'h1;
    start_burst(27'h11, s, 6'd2);
    app_rdata_valid = 1'b0;
    n_checks++;
    if (err_cnt !== 16'd1 || first_err_beat !== 6'h3F || chk_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL start_orphan: err=%0d beat=%0h busy=%0b, required 1 3f 1", err_cnt, first_err_beat, chk_busy);
    end
    send_beats(s, 3, 2, -1, 1'b1);
    wait_done();
    n_checks++;
    if (ok_cnt !== 32'd1 || err_cnt !== 16'd1) begin
      n_fail++; $display("FAIL start_orphan_burst: ok=%0d err=%0d, required 1 1", ok_cnt, err_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] s;
    s = 128'h4242;
    start_burst(27'h12, s, 6'd3);
    send_beats(s, 2, 3, -1, 1'b1);
    rst = 1'b1;
    #1;
    n_checks++;
    if (chk_busy !== 1'b0 || chk_done !== 1'b0 || err_cnt !== 16'd0 || ok_cnt !== 32'd0 ||
        err_sticky !== 1'b0 || first_err_beat !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%0b err=%0d ok=%0d sticky=%0b, required all zero",
               chk_busy, err_cnt, ok_cnt, err_sticky);
    end
    step(); step();
    rst = 1'b0;
    repeat (20) step();   // an aborted burst must not report
    start_burst(27'h13, s, 6'd3);
    send_beats(s, 4, 3, -1, 1'b1);
    wait_done();
    n_checks++;
    if (ok_cnt !== 32'd1 || err_cnt !== 16'd0) begin
      n_fail++; $display("FAIL after_reset: ok=%0d err=%0d, required 1 0", ok_cnt, err_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_wrap();
    test_mismatch();
    test_clr_collide();
    test_timeout();
    test_orphan();
    test_start_orphan();
    test_reset_mid();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
